// File: rtl/counter_seq_pkg.sv
//------------------------------------------------------------------------------
// counter_seq_pkg : opcode and state encodings shared by counter_sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package counter_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_RUN   = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/counter_sequencer.sv
//------------------------------------------------------------------------------
// counter_sequencer : drives load/increment strobes of a downstream counter
//                     from a command port and keeps a shadow of its value.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              set,
  output logic              ena,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] exp_count
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic [DATA_W-1:0]  exp_q, exp_d;
  logic               set_q, set_d;
  logic               ena_q, ena_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               w_accept;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    set_d   = 1'b0;
    ena_d   = 1'b0;
    din_d   = '0;
    done_d  = 1'b0;

    // Shadow follows the strobes currently presented to the downstream counter
    exp_d = exp_q;
    if (set_q) begin
      exp_d = din_q;
    end else if (ena_q) begin
      exp_d = exp_q + DATA_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          case (op_e'(cmd_op))
            OP_LOAD: begin
              state_d = ST_LOAD;
              set_d   = 1'b1;
              din_d   = cmd_data;
            end
            OP_CLEAR: begin
              state_d = ST_LOAD;
              set_d   = 1'b1;
            end
            OP_RUN: begin
              if (cmd_data != '0) begin
                state_d = ST_RUN;
                ena_d   = 1'b1;
                rem_d   = cmd_data;
              end else begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      ST_LOAD: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_RUN: begin
        rem_d = rem_q - DATA_W'(1);
        if (rem_q == DATA_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          ena_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      din_q   <= '0;
      exp_q   <= '0;
      set_q   <= 1'b0;
      ena_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      din_q   <= din_d;
      exp_q   <= exp_d;
      set_q   <= set_d;
      ena_q   <= ena_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign set       = set_q;
  assign ena       = ena_q;
  assign din       = din_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign exp_count = exp_q;

endmodule

`default_nettype wire

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of command data, din and exp_count.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command can be accepted.
REQ-006 SHALL have port cmd_op  input  2  opcode: 0 NOP, 1 LOAD, 2 RUN, 3 CLEAR.
REQ-007 SHALL have port cmd_data  input  DATA_W  load value (LOAD) or increment count (RUN).
REQ-008 SHALL have port set  output  1  downstream counter load strobe.
REQ-009 SHALL have port ena  output  1  downstream counter increment enable.
REQ-010 SHALL have port din  output  DATA_W  downstream counter load value.
REQ-011 SHALL have port busy  output  1  command in progress (state not IDLE).
REQ-012 SHALL have port done  output  1  single-cycle command-complete pulse.
REQ-013 SHALL have port exp_count  output  DATA_W  shadow of downstream counter value.

Function
REQ-014 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-015 SHALL drive cmd_ready high only in IDLE with rst low.
REQ-016 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high (acceptance edge); cmd_valid while not ready SHALL be ignored.
REQ-017 SHALL, on LOAD accepted, go to LOAD: set=1 and din=cmd_data for exactly one cycle, then DONE.
REQ-018 SHALL treat CLEAR exactly as LOAD with din=0, ignoring cmd_data.
REQ-019 SHALL, on RUN with cmd_data=N>0, go to RUN: ena=1 for exactly N consecutive cycles, then DONE.
REQ-020 SHALL, on RUN with N=0 or on NOP, go directly to DONE; set and ena stay low.
REQ-021 SHALL use an internal DATA_W-bit remaining-count register loaded with N and decremented each RUN cycle; RUN exits when it reaches 1 on a RUN cycle.
REQ-022 SHALL assert done for exactly one cycle in DONE, then return to IDLE; minimum command spacing 3 cycles (LOAD/CLEAR, RUN N=1), 2 cycles (NOP, RUN N=0).
REQ-023 SHALL make set, ena, din, done and busy registered outputs; set and ena never high together.
REQ-024 SHALL hold din at 0 whenever set is low.
REQ-025 SHALL update exp_count on each edge where set=1 (exp_count<=din) or ena=1 (exp_count<=exp_count+1, modulo 2^DATA_W, 255->0 wraps for DATA_W=8).
REQ-026 SHALL keep exp_count unchanged when neither set nor ena is high.

Reset
REQ-027 SHALL, on any edge with rst high, force state IDLE, set=0, ena=0, din=0, done=0, busy=0, exp_count=0, remaining count=0.
REQ-028 SHALL abort an in-progress LOAD/RUN on reset without generating done; ena low from the first edge with rst sampled high.
REQ-029 SHALL hold cmd_ready low while rst is high; a command presented during reset is not accepted.

Structure
REQ-030 SHALL place the opcode enum (NOP/LOAD/RUN/CLEAR) and state enum in shared package counter_seq_pkg.
REQ-031 SHALL be a single module without sub-modules; state register, remaining counter and exp_count in one always_ff block.

Verification
REQ-032 After reset, LOAD 0x5A accepted at edge t -> set=1, din=0x5A in cycle t+1; done=1 in t+2; cmd_ready=1 in t+3; exp_count=0x5A.
REQ-033 LOAD 0xFD then RUN 5 -> ena high exactly 5 cycles, exp_count 0xFE,0xFF,0x00,0x01,0x02; one done pulse per command.
REQ-034 RUN 0 and NOP -> set/ena never high, done one cycle after acceptance, exp_count unchanged.
REQ-035 cmd_valid held high with new cmd_op/cmd_data while busy -> no acceptance until IDLE; accepted command is the one present when cmd_ready high.
REQ-036 rst high for one cycle during RUN 200 at remaining count 100 -> ena=0, busy=0, exp_count=0 next cycle, no done pulse; next RUN 3 gives exp_count=3.
REQ-037 Random command stream (1000 commands) against a cycle model of the downstream counter -> exp_count equals model count every cycle; set&ena never both 1.
